// File: rtl/izh_scheduler_if.sv
// izh_dp_if: request/response handshake between the scheduler and the shared neuron datapath
interface izh_dp_if #(
   parameter int STATE_W = 8,
   parameter int CUR_W   = 8
);
   logic               dp_start;
   logic [CUR_W-1:0]   dp_cur;
   logic [STATE_W-1:0] dp_v_in;
   logic               dp_done;
   logic [STATE_W-1:0] dp_v_out;
   logic               dp_spike;
   modport master (output dp_start, dp_cur, dp_v_in, input dp_done, dp_v_out, dp_spike);
   modport slave  (input dp_start, dp_cur, dp_v_in, output dp_done, dp_v_out, dp_spike);
endinterface

// File: rtl/izh_scheduler.sv
// izh_scheduler: time-multiplexes one Izhikevich datapath over N_NEURONS virtual neurons per tick
module izh_scheduler #(
   parameter int                 N_NEURONS = 4,
   parameter int                 STATE_W   = 8,
   parameter int                 CUR_W     = 8,
   parameter int                 TICK_DIV  = 64,
   parameter logic [STATE_W-1:0] V_RESET   = '0,
   parameter int                 AW        = $clog2(N_NEURONS)
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 run,
   input  logic                 cfg_we,
   input  logic [AW-1:0]        cfg_addr,
   input  logic [CUR_W-1:0]     cfg_data,
   input  logic [AW-1:0]        rd_addr,
   output logic [STATE_W-1:0]   rd_state,
   izh_dp_if.master             dp,
   output logic [N_NEURONS-1:0] spike_vec,
   output logic                 step_done,
   output logic                 busy,
   output logic                 overrun
);
   localparam int CW = $clog2(TICK_DIV);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, COMMIT} fsm_t;
   fsm_t                 fsm_q, fsm_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [AW-1:0]        idx_q, idx_d;
   logic [STATE_W-1:0]   st_q [N_NEURONS];
   logic [STATE_W-1:0]   st_d [N_NEURONS];
   logic [CUR_W-1:0]     cur_q [N_NEURONS];
   logic [CUR_W-1:0]     cur_d [N_NEURONS];
   logic [STATE_W-1:0]   cap_v_q, cap_v_d;
   logic                 cap_s_q, cap_s_d;
   logic [N_NEURONS-1:0] sh_q, sh_d, sv_q, sv_d, sh_nxt;
   logic                 sd_q, sd_d, ovr_q, ovr_d, tick, last;
   always_comb begin
      tick    = run && 32'(cnt_q) == TICK_DIV - 1;
      last    = 32'(idx_q) == N_NEURONS - 1;
      cnt_d   = (!run || tick) ? '0 : cnt_q + 1'b1;
      fsm_d   = fsm_q;
      idx_d   = idx_q;
      st_d    = st_q;
      cur_d   = cur_q;
      cap_v_d = cap_v_q;
      cap_s_d = cap_s_q;
      sh_d    = sh_q;
      sv_d    = sv_q;
      sd_d    = 1'b0;
      sh_nxt  = sh_q;
      sh_nxt[idx_q] = cap_s_q;
      ovr_d   = ovr_q | (tick && fsm_q != IDLE);
      if (cfg_we && 32'(cfg_addr) < N_NEURONS) cur_d[cfg_addr] = cfg_data;
      case (fsm_q)
         IDLE: if (tick) begin
            idx_d = '0;
            sh_d  = '0;
            fsm_d = ISSUE;
         end
         ISSUE: fsm_d = WAIT;
         WAIT: if (dp.dp_done) begin
            cap_v_d = dp.dp_v_out;
            cap_s_d = dp.dp_spike;
            fsm_d   = COMMIT;
         end
         COMMIT: begin
            st_d[idx_q] = cap_v_q;
            sh_d        = sh_nxt;
            sv_d        = last ? sh_nxt : sv_q;
            sd_d        = last;
            idx_d       = last ? idx_q : idx_q + 1'b1;
            fsm_d       = last ? IDLE : ISSUE;
         end
         default: fsm_d = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         fsm_q   <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         st_q    <= '{default: V_RESET};
         cur_q   <= '{default: '0};
         cap_v_q <= '0;
         cap_s_q <= 1'b0;
         sh_q    <= '0;
         sv_q    <= '0;
         sd_q    <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         fsm_q   <= fsm_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         st_q    <= st_d;
         cur_q   <= cur_d;
         cap_v_q <= cap_v_d;
         cap_s_q <= cap_s_d;
         sh_q    <= sh_d;
         sv_q    <= sv_d;
         sd_q    <= sd_d;
         ovr_q   <= ovr_d;
      end
   end
   assign dp.dp_start = fsm_q == ISSUE;
   assign dp.dp_cur   = cur_q[idx_q];
   assign dp.dp_v_in  = st_q[idx_q];
   assign rd_state    = 32'(rd_addr) < N_NEURONS ? st_q[rd_addr] : '0;
   assign spike_vec   = sv_q;
   assign step_done   = sd_q;
   assign busy        = fsm_q != IDLE;
   assign overrun     = ovr_q;
endmodule

// File: tb/tb_izh_scheduler.sv
// tb_izh_scheduler: directed table-driven bench with a latency-programmable datapath model
module tb_izh_scheduler;
   typedef struct packed {
      logic [3:0]      mask;
      logic [3:0][7:0] cur;
      logic [3:0]      sv;
      logic [3:0][7:0] st;
   } vec_t;
   logic       clk = 0, reset_n = 0, run = 0, cfg_we = 0;
   logic [1:0] cfg_addr = 0, rd_addr = 0;
   logic [7:0] cfg_data = 0, rd_state;
   logic [3:0] spike_vec;
   logic       step_done, busy, overrun;
   int         total = 0, bad = 0, sz0 = 0, lat = 1, cd = 0, cyc = 0;
   logic [3:0] mask = 0;
   logic [1:0] nidx = 0;
   logic [7:0] mv = 0;
   logic       ms = 0;
   int         q_cyc[$];
   logic [7:0] q_cur[$], q_vin[$];
   vec_t       tbl[5];
   logic [3:0][7:0] prev;
   izh_dp_if #(.STATE_W(8), .CUR_W(8)) dif();
   izh_scheduler #(.N_NEURONS(4), .STATE_W(8), .CUR_W(8), .TICK_DIV(16), .V_RESET(8'd0)) dut (
      .clk(clk), .reset_n(reset_n), .run(run), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
      .cfg_data(cfg_data), .rd_addr(rd_addr), .rd_state(rd_state), .dp(dif),
      .spike_vec(spike_vec), .step_done(step_done), .busy(busy), .overrun(overrun)
   );
   always #5 clk = ~clk;
   assign dif.dp_done  = cd == 1;
   assign dif.dp_v_out = mv;
   assign dif.dp_spike = ms;
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (dif.dp_start) begin
         q_cyc.push_back(cyc);
         q_cur.push_back(dif.dp_cur);
         q_vin.push_back(dif.dp_v_in);
      end
      if (!reset_n) begin
         cd   <= 0;
         nidx <= 0;
      end else if (dif.dp_start) begin
         cd   <= lat;
         mv   <= dif.dp_v_in + dif.dp_cur;
         ms   <= mask[nidx];
         nidx <= nidx + 1'b1;
      end else if (cd != 0) cd <= cd - 1;
   end
   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s got=%0d want=%0d", nm, act, exp);
      end
   endtask
   task automatic rd_chk(input logic [3:0][7:0] est);
      for (int i = 0; i < 4; i++) begin
         rd_addr = 2'(i);
         #1;
         chk($sformatf("rd_state[%0d]", i), int'(rd_state), int'(est[i]));
      end
   endtask
   task automatic wr_all(input logic [3:0][7:0] c);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         cfg_we = 1; cfg_addr = 2'(i); cfg_data = c[i];
         @(negedge clk);
         cfg_we = 0;
      end
   endtask
   task automatic run_step(input int l, input logic [3:0] m, input logic [3:0][7:0] c,
                           input logic [3:0][7:0] pv, input logic [3:0] esv,
                           input logic [3:0][7:0] est, input int inj, input int drop);
      int base, n, sd;
      bit seen;
      lat = l; mask = m; base = q_cyc.size(); seen = 0; sd = 0;
      run = 1;
      for (int k = 0; k < 300 && !seen; k++) begin
         @(negedge clk);
         cfg_we = 0;
         if (inj >= 0 && dif.dp_start && q_cyc.size() - base == inj) begin
            cfg_we = 1; cfg_addr = 2'(inj); cfg_data = 8'd99;
         end
         if (drop >= 0 && q_cyc.size() - base > drop) run = 0;
         if (step_done) begin seen = 1; sd = cyc; run = 0; end
      end
      cfg_we = 0;
      chk("step_done_seen", int'(seen), 1);
      n = q_cyc.size() - base;
      chk("pulse_count", n, 4);
      for (int i = 0; i < n && i < 4; i++) begin
         chk($sformatf("dp_cur[%0d]", i), int'(q_cur[base+i]), int'(c[i]));
         chk($sformatf("dp_v_in[%0d]", i), int'(q_vin[base+i]), int'(pv[i]));
         if (i > 0) chk($sformatf("spacing[%0d]", i), q_cyc[base+i] - q_cyc[base+i-1], l + 2);
      end
      if (n > 0) chk("done_latency", sd - q_cyc[base+n-1], l + 2);
      chk("spike_vec", int'(spike_vec), int'(esv));
      rd_chk(est);
      @(negedge clk);
      chk("step_done_pulse", int'(step_done), 0);
   endtask
   initial begin
      tbl[0] = '{mask: 4'b0000, cur: {8'd20, 8'd15, 8'd10, 8'd5},  sv: 4'b0000, st: {8'd20, 8'd15, 8'd10, 8'd5}};
      tbl[1] = '{mask: 4'b1010, cur: {8'd20, 8'd15, 8'd10, 8'd5},  sv: 4'b1010, st: {8'd40, 8'd30, 8'd20, 8'd10}};
      tbl[2] = '{mask: 4'b0000, cur: {8'd20, 8'd15, 8'd10, 8'd5},  sv: 4'b0000, st: {8'd60, 8'd45, 8'd30, 8'd15}};
      tbl[3] = '{mask: 4'b1111, cur: {8'd3, 8'd2, 8'd1, 8'd250},   sv: 4'b1111, st: {8'd63, 8'd47, 8'd31, 8'd9}};
      tbl[4] = '{mask: 4'b0001, cur: {8'd0, 8'd0, 8'd0, 8'd0},     sv: 4'b0001, st: {8'd63, 8'd47, 8'd31, 8'd9}};
      reset_n = 0; run = 1;
      @(negedge clk);
      sz0 = q_cyc.size();
      repeat (2) @(negedge clk);
      chk("rst_dp_start", int'(dif.dp_start), 0);
      chk("rst_step_done", int'(step_done), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_overrun", int'(overrun), 0);
      chk("rst_spike_vec", int'(spike_vec), 0);
      chk("rst_no_pulses", q_cyc.size(), sz0);
      rd_chk('0);
      reset_n = 1; run = 0;
      prev = '0;
      for (int v = 0; v < 5; v++) begin
         wr_all(tbl[v].cur);
         run_step(1, tbl[v].mask, tbl[v].cur, prev, tbl[v].sv, tbl[v].st, -1, -1);
         prev = tbl[v].st;
      end
      chk("no_overrun_yet", int'(overrun), 0);
      // neuron 2 gets 99 in its own ISSUE cycle: old value 3 this step, 99 next step
      wr_all({8'd4, 8'd3, 8'd2, 8'd1});
      run_step(1, 4'b0, {8'd4, 8'd3, 8'd2, 8'd1}, {8'd63, 8'd47, 8'd31, 8'd9}, 4'b0, {8'd67, 8'd50, 8'd33, 8'd10}, 2, -1);
      run_step(1, 4'b0, {8'd4, 8'd99, 8'd2, 8'd1}, {8'd67, 8'd50, 8'd33, 8'd10}, 4'b0, {8'd71, 8'd149, 8'd35, 8'd11}, -1, -1);
      run_step(1, 4'b0, {8'd4, 8'd99, 8'd2, 8'd1}, {8'd71, 8'd149, 8'd35, 8'd11}, 4'b0, {8'd75, 8'd248, 8'd37, 8'd12}, -1, 1);
      sz0 = q_cyc.size();
      repeat (40) @(negedge clk);
      chk("run0_no_pulses", q_cyc.size(), sz0);
      chk("run0_busy", int'(busy), 0);
      chk("pre_overrun", int'(overrun), 0);
      run_step(5, 4'b0100, {8'd4, 8'd99, 8'd2, 8'd1}, {8'd75, 8'd248, 8'd37, 8'd12}, 4'b0100, {8'd79, 8'd91, 8'd39, 8'd13}, -1, -1);
      chk("overrun_set", int'(overrun), 1);
      run_step(5, 4'b0, {8'd4, 8'd99, 8'd2, 8'd1}, {8'd79, 8'd91, 8'd39, 8'd13}, 4'b0, {8'd83, 8'd190, 8'd41, 8'd14}, -1, -1);
      chk("overrun_sticky", int'(overrun), 1);
      lat = 5; mask = 0; sz0 = q_cyc.size(); run = 1;
      for (int k = 0; k < 200 && q_cyc.size() - sz0 < 2; k++) @(negedge clk);
      chk("reach_n1_wait", q_cyc.size() - sz0, 2);
      reset_n = 0; run = 0;
      repeat (2) @(negedge clk);
      reset_n = 1;
      chk("mid_rst_busy", int'(busy), 0);
      chk("mid_rst_overrun", int'(overrun), 0);
      chk("mid_rst_spike_vec", int'(spike_vec), 0);
      chk("mid_rst_step_done", int'(step_done), 0);
      rd_chk('0);
      sz0 = q_cyc.size();
      repeat (20) @(negedge clk);
      chk("mid_rst_no_pulses", q_cyc.size(), sz0);
      rd_chk('0);
      wr_all({8'd10, 8'd9, 8'd8, 8'd7});
      run_step(1, 4'b0, {8'd10, 8'd9, 8'd8, 8'd7}, '0, 4'b0, {8'd10, 8'd9, 8'd8, 8'd7}, -1, -1);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
